// File: rtl/ef_pwm32_seq_pkg.sv
// Shared types and constants for the PWM compare-update sequencer.
package ef_pwm32_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_A_ADDR = 2'd1,
        ST_B_ADDR = 2'd2,
        ST_B_DATA = 2'd3
    } seq_state_e;

    localparam logic [31:0] CMPA_OFS = 32'h0000_0000;
    localparam logic [31:0] CMPB_OFS = 32'h0000_0004;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ef_pwm32_seq_fifo.sv
// Synchronous FIFO holding {cmpa, cmpb} pairs; head entry is visible
// combinationally so a pop can load the holding registers on the same edge.
module ef_pwm32_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge HCLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + LW'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/ef_pwm32_seq.sv
// AHB-Lite master that writes one queued {cmpA, cmpB} pair into an ef_pwm32
// slave on each enabled period tick, as two pipelined word writes.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for tick; HTRANS=IDLE, HADDR holds last value
// ST_A_ADDR | CMPA address phase (NONSEQ, HADDR=PWM_BASE)
// ST_B_ADDR | CMPB address phase + CMPA data phase (HWDATA=ha)
// ST_B_DATA | CMPB data phase (HWDATA=hb), HTRANS=IDLE
module ef_pwm32_seq
    import ef_pwm32_seq_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] PWM_BASE = 32'h0000_0000
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     en,
    input  logic                     tick,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_cmpa,
    input  logic [31:0]              cmd_cmpb,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     underrun,
    output logic                     overrun,
    output logic [31:0]              HADDR,
    output logic [1:0]               HTRANS,
    output logic                     HWRITE,
    output logic [2:0]               HSIZE,
    output logic [31:0]              HWDATA,
    input  logic                     HREADY
);
    localparam logic [31:0] ADDR_A = PWM_BASE + CMPA_OFS;
    localparam logic [31:0] ADDR_B = PWM_BASE + CMPB_OFS;

    seq_state_e  state_q;
    seq_state_e  state_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [63:0] fifo_rd;
    logic [31:0] ha_q;
    logic [31:0] hb_q;
    logic [31:0] haddr_q;
    logic [31:0] hwdata_q;
    logic        tick_ok;
    logic        underrun_d;
    logic        overrun_d;

    assign cmd_ready = !fifo_full;
    assign tick_ok   = tick && en;

    ef_pwm32_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (cmd_valid && cmd_ready),
        .wr_data ({cmd_cmpa, cmd_cmpb}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pop and error-pulse decode; ticks outside IDLE are dropped.
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_ok) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_A_ADDR;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_A_ADDR: begin
                overrun_d = tick_ok;
                if (HREADY) state_d = ST_B_ADDR;
            end
            ST_B_ADDR: begin
                overrun_d = tick_ok;
                if (HREADY) state_d = ST_B_DATA;
            end
            ST_B_DATA: begin
                overrun_d = tick_ok;
                if (HREADY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Holding registers capture the popped pair so the FIFO may refill freely.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ha_q <= '0;
            hb_q <= '0;
        end else if (fifo_pop) begin
            ha_q <= fifo_rd[63:32];
            hb_q <= fifo_rd[31:0];
        end
    end

    // Address/data registers follow the next state, so a stalled phase
    // simply reloads the same value and IDLE leaves them untouched.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q  <= '0;
            hwdata_q <= '0;
        end else begin
            case (state_d)
                ST_A_ADDR: haddr_q <= ADDR_A;
                ST_B_ADDR: begin
                    haddr_q  <= ADDR_B;
                    hwdata_q <= ha_q;
                end
                ST_B_DATA: hwdata_q <= hb_q;
                default: ;
            endcase
        end
    end

    // Error pulses are registered so they appear the cycle after the tick.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= underrun_d;
            overrun  <= overrun_d;
        end
    end

    // Bus control decodes directly from the registered state.
    always_comb begin
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        if (state_q == ST_A_ADDR || state_q == ST_B_ADDR) begin
            HTRANS = HTRANS_NONSEQ;
            HWRITE = 1'b1;
        end
    end

    assign HSIZE  = HSIZE_WORD;
    assign HADDR  = haddr_q;
    assign HWDATA = hwdata_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: doc/ef_pwm32_seq.md
# ef_pwm32_seq

AHB-Lite master that sequences duty-cycle updates into one ef_pwm32 AHB-Lite slave. Software or a DMA pushes {cmpA, cmpB} pairs into an internal FIFO. On each period-boundary tick the block pops one pair and issues two back-to-back word writes: CMPA at `PWM_BASE+0x0`, then CMPB at `PWM_BASE+0x4`. It sits between the update producer and the PWM slave's bus port.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, minimum 2.
- `PWM_BASE`, 32'h0000_0000 — byte base address of the target PWM slave.

Ports:
- `HCLK` in 1 — clock.
- `HRESETn` in 1 — reset, asynchronous, active-low.
- `en` in 1 — enables tick servicing.
- `tick` in 1 — single-cycle period-boundary pulse, synchronous to HCLK.
- `cmd_valid` in 1 — push request.
- `cmd_ready` out 1 — FIFO not full.
- `cmd_cmpa` in 32 — cmpA value to push.
- `cmd_cmpb` in 32 — cmpB value to push.
- `level` out $clog2(DEPTH)+1 — FIFO occupancy.
- `busy` out 1 — write pair in progress.
- `underrun` out 1 — one-cycle pulse: serviced tick found the FIFO empty.
- `overrun` out 1 — one-cycle pulse: tick arrived while busy.
- `HADDR` out 32 — AHB address.
- `HTRANS` out 2 — AHB transfer type.
- `HWRITE` out 1 — AHB write.
- `HSIZE` out 3 — AHB size.
- `HWDATA` out 32 — AHB write data.
- `HREADY` in 1 — AHB ready.

## Operation
- **FIFO**
  - Push when `cmd_valid & cmd_ready`.
  - `cmd_ready = (level != DEPTH)`.
  - Pop only from state IDLE on an accepted tick.
  - Same-cycle push and pop leave `level` unchanged.
  - A push into an empty FIFO is poppable from the next cycle on.
- **FSM states:** IDLE, A_ADDR, B_ADDR, B_DATA.
  - IDLE, tick & en & level≠0: pop into holding registers {ha, hb}, go to A_ADDR.
  - IDLE, tick & en & level==0: pulse `underrun`, stay in IDLE.
  - A_ADDR: drive NONSEQ, HADDR=`PWM_BASE`. Go to B_ADDR when HREADY.
  - B_ADDR: drive NONSEQ, HADDR=`PWM_BASE+4`, HWDATA=ha. Go to B_DATA when HREADY.
  - B_DATA: drive IDLE, HWDATA=hb. Go to IDLE when HREADY.
- **Bus fields**
  - `HWRITE=1` in A_ADDR and B_ADDR, 0 otherwise.
  - `HSIZE=3'b010` always.
  - HTRANS is only ever IDLE (2'b00) or NONSEQ (2'b10).
- **Held values**
  - HADDR/HWDATA hold their value while HREADY is low.
  - HADDR holds its last value in IDLE.
- `busy` is 1 in every state except IDLE.
- A tick in any non-IDLE state is dropped and pulses `overrun`.
- Ticks with `en`=0 are ignored with no pulses.
- Deasserting `en` mid-pair does not abort; the pair completes.
- Address arithmetic is modulo 2^32.

## Timing
- **Reset values:** HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0, busy=0, underrun=0, overrun=0, level=0, cmd_ready=1, FSM=IDLE.
- **Zero-wait sequence**, tick sampled at edge T:
  - Cycle T+1: CMPA address phase.
  - Cycle T+2: CMPB address phase, CMPA data.
  - Cycle T+3: CMPB data, HTRANS=IDLE.
  - Cycle T+4: busy=0.
  - A tick at T+4 is serviced.
- Each HREADY-low cycle extends the current phase by one cycle.
- `underrun`/`overrun` assert the cycle after the offending tick.
- **Reset mid-operation:** all state clears asynchronously and FIFO contents are lost. A partially issued pair may leave CMPA updated without CMPB; this is accepted.

## Structure
- Package `ef_pwm32_seq_pkg`:
  - FSM state enum.
  - Constants `CMPA_OFS=32'h0`, `CMPB_OFS=32'h4`.
  - HTRANS codes IDLE/NONSEQ.
  - `HSIZE_WORD=3'b010`.
- Sub-module `ef_pwm32_seq_fifo`:
  - Synchronous FIFO, 64 bits wide, DEPTH entries.
  - Pointer wrap on DEPTH; occupancy counter; async reset.
- Top level holds the FSM, holding registers and AHB drive.

## Test plan
- Push (0x10, 0x20), en=1, pulse tick, HREADY=1 → writes 0x10 to PWM_BASE and 0x20 to PWM_BASE+4 in cycles T+1..T+3; level 1→0; busy high for exactly 3 cycles.
- Same as above with HREADY low for 2 cycles during the CMPB address phase → HADDR=PWM_BASE+4 and HWDATA=0x10 held; busy lasts 5 cycles; data unchanged.
- Push DEPTH+1 entries with no ticks → cmd_ready=0 after DEPTH pushes; extra entry refused; level=DEPTH. Then DEPTH ticks drain entries in push order.
- Tick with empty FIFO → underrun pulses once, no AHB transfer. Tick at T+2 of an active pair → overrun pulses, no extra pair.
- Push while level==DEPTH-1 in the same cycle as a tick pop → level stays DEPTH-1; cmd_ready stays 1.
- Assert HRESETn low during B_ADDR → outputs return to reset values immediately; level=0; next tick after release produces underrun.
